// File: rtl/ddr3_dma_pkg.sv
// Shared definitions for the DDR3 DMA stream writer/drainer blocks.
// FSM encoding, default counter width and ping-pong half selectors.
package ddr3_dma_pkg;

    localparam int unsigned SIZE_WIDTH_DEF = 24;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    localparam logic [1:0] PP_HALF0 = 2'b01;
    localparam logic [1:0] PP_HALF1 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_RELEASE = 2'd2
    } dma_state_t;

endpackage

// File: rtl/ddr3_dma_idle_timer.sv
// Saturating idle down-counter: reload on clear, count on enable, flag the
// enabled cycle on which TIMEOUT idle cycles have elapsed. TIMEOUT=0 disables.
module ddr3_dma_idle_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LOAD = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= LOAD;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired_c = (TIMEOUT != 0) && i_enable && (r_count == '0);

endmodule

// File: rtl/ddr3_dma_stream_writer.sv
// Packs a valid/ready word stream into one ping-pong FIFO half at a time,
// releasing the half when full, on stream last, on flush or on idle timeout.
module ddr3_dma_stream_writer
    import ddr3_dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned SIZE_WIDTH   = SIZE_WIDTH_DEF,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_last,
    input  logic                  i_flush,
    input  logic [1:0]            write_ready,
    output logic [1:0]            write_activate,
    input  logic [SIZE_WIDTH-1:0] write_size,
    output logic                  write_strobe,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  o_busy,
    output logic [31:0]           o_total_count
);

    dma_state_t            r_state;
    dma_state_t            w_state_next;
    logic [1:0]            r_activate, w_activate_n;
    logic [SIZE_WIDTH-1:0] r_cnt, w_cnt_n;
    logic [SIZE_WIDTH-1:0] r_cap, w_cap_n;
    logic                  r_strobe, w_strobe_n;
    logic [DATA_WIDTH-1:0] r_data, w_data_n;
    logic [31:0]           r_total, w_total_n;
    logic                  w_timer_clr, w_timer_en, w_expired;
    logic                  w_accept, w_release, w_grant;
    logic [SIZE_WIDTH-1:0] w_cnt_inc, w_cnt_eff;

    // Ready depends on registers only so upstream never sees a valid->ready path.
    assign o_ready   = (r_state == ST_XFER) && (r_cnt < r_cap);
    assign w_accept  = i_valid && o_ready;
    assign w_cnt_inc = r_cnt + SIZE_WIDTH'(1);
    assign w_cnt_eff = w_accept ? w_cnt_inc : r_cnt;
    assign w_grant   = (r_activate == 2'b00) && (write_ready != 2'b00);

    // An empty half is never released, whatever the trigger.
    assign w_release = (w_accept && (w_cnt_inc == r_cap))
                     || (w_accept && i_last)
                     || (i_flush && (w_cnt_eff != '0))
                     || (w_expired && (r_cnt != '0));

    ddr3_dma_idle_timer #(
        .TIMEOUT(IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_timer_clr),
        .i_enable   (w_timer_en),
        .o_expired_c(w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_grant) w_state_next = ST_XFER;
            ST_XFER:    if (w_release) w_state_next = ST_RELEASE;
            ST_RELEASE: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Ownership is dropped on the first IDLE edge, after the final strobe has landed.
    always_comb begin
        w_activate_n = r_activate;
        w_cnt_n      = r_cnt;
        w_cap_n      = r_cap;
        w_strobe_n   = 1'b0;
        w_data_n     = r_data;
        w_total_n    = r_total;
        w_timer_clr  = 1'b0;
        w_timer_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_activate != 2'b00) begin
                    w_activate_n = 2'b00;
                end else if (write_ready != 2'b00) begin
                    w_activate_n = write_ready[0] ? PP_HALF0 : PP_HALF1;
                    w_cap_n      = (write_size == '0) ? SIZE_WIDTH'(1) : write_size;
                    w_cnt_n      = '0;
                    w_timer_clr  = 1'b1;
                end
            end
            ST_XFER: begin
                if (w_accept) begin
                    w_strobe_n  = 1'b1;
                    w_data_n    = i_data;
                    w_cnt_n     = w_cnt_inc;
                    w_total_n   = r_total + 32'd1;
                    w_timer_clr = 1'b1;
                end else begin
                    w_timer_en  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_activate <= 2'b00;
            r_cnt      <= '0;
            r_cap      <= '0;
            r_strobe   <= 1'b0;
            r_data     <= '0;
            r_total    <= '0;
        end else begin
            r_activate <= w_activate_n;
            r_cnt      <= w_cnt_n;
            r_cap      <= w_cap_n;
            r_strobe   <= w_strobe_n;
            r_data     <= w_data_n;
            r_total    <= w_total_n;
        end
    end

    assign write_activate = r_activate;
    assign write_strobe   = r_strobe;
    assign write_data     = r_data;
    assign o_total_count  = r_total;
    assign o_busy         = (r_activate != 2'b00);

endmodule

// File: tb/tb_ddr3_dma_stream_writer.sv
// Directed and randomized bench for ddr3_dma_stream_writer against a
// word-queue/ownership reference model with a ping-pong ready model.
module tb_ddr3_dma_stream_writer;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 24;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] i_data;
    logic          i_valid, i_last, i_flush;
    logic          o_ready;
    logic [1:0]    write_ready;
    logic [1:0]    write_activate;
    logic [SW-1:0] write_size;
    logic          write_strobe;
    logic [DW-1:0] write_data;
    logic          o_busy;
    logic [31:0]   o_total_count;

    ddr3_dma_stream_writer #(
        .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .i_last(i_last), .i_flush(i_flush),
        .write_ready(write_ready), .write_activate(write_activate),
        .write_size(write_size), .write_strobe(write_strobe),
        .write_data(write_data), .o_busy(o_busy),
        .o_total_count(o_total_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    int         n_chk = 0;
    int         n_fail = 0;
    word_t      exp_q[$];
    logic [1:0] grants[$];
    int         halves[$];
    int         cur_n = 0;
    int         cur_cap = 0;
    logic       cur_last = 1'b0;
    logic [1:0] prev_act = 2'b00;
    longint     m_total = 0;
    bit         model_on = 1'b0;
    bit         chk_caps = 1'b0;
    int         refill[2] = '{0, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: capture pre-edge handshake, then update the model and check outputs.
    task automatic cyc();
        logic          acc, r;
        logic [SW-1:0] sz;
        word_t         w;
        r    = rst;
        acc  = !rst && i_valid && o_ready;
        sz   = write_size;
        w.d  = i_data;
        w.l  = i_last;
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            m_total = 0;
            cur_n   = 0;
        end else if (acc) begin
            exp_q.push_back(w);
            m_total++;
        end
        if (write_strobe) begin
            chk("strobe_owned", 64'(write_activate != 2'b00), 64'd1);
            if (exp_q.size() == 0) begin
                chk("strobe_unexpected", 64'd1, 64'd0);
            end else begin
                w = exp_q.pop_front();
                chk("strobe_data", 64'(write_data), 64'(w.d));
                cur_n++;
                cur_last = w.l;
            end
        end
        chk("total_count", 64'(o_total_count), 64'(m_total[31:0]));
        chk("act_onehot", 64'(write_activate == 2'b11), 64'd0);
        chk("busy", 64'(o_busy), 64'(write_activate != 2'b00));
        for (int i = 0; i < 2; i++) begin
            if (refill[i] > 0) begin
                refill[i]--;
                if (refill[i] == 0 && model_on) write_ready[i] = 1'b1;
            end
        end
        if (prev_act == 2'b00 && write_activate != 2'b00) begin
            grants.push_back(write_activate);
            cur_n    = 0;
            cur_last = 1'b0;
            cur_cap  = (sz == '0) ? 1 : int'(sz);
            if (model_on) write_ready = write_ready & ~write_activate;
        end
        if (prev_act != 2'b00 && write_activate == 2'b00) begin
            halves.push_back(cur_n);
            if (chk_caps) begin
                chk("half_cap_bound", 64'(cur_n <= cur_cap), 64'd1);
                chk("half_release_reason", 64'((cur_n == cur_cap) || cur_last), 64'd1);
            end
            if (model_on) refill[prev_act[1] ? 1 : 0] = 6;
        end
        prev_act = write_activate;
    endtask

    task automatic send(input int n, input bit last_final);
        bit acc;
        int b;
        for (int k = 0; k < n; k++) begin
            i_data  = $urandom();
            i_valid = 1'b1;
            i_last  = last_final && (k == n - 1);
            b = 0;
            do begin
                acc = !rst && i_valid && o_ready;
                cyc();
                b++;
            end while (!acc && b < 100);
            if (!acc) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_act(input bit want_busy, input int budget, input string tag);
        int b = 0;
        while (((write_activate != 2'b00) != want_busy) && b < budget) begin
            cyc();
            b++;
        end
        chk(tag, 64'(write_activate != 2'b00), 64'(want_busy));
    endtask

    task automatic grant_one(input logic [1:0] rdy, input logic [SW-1:0] sz, input string tag);
        write_ready = rdy;
        write_size  = sz;
        wait_act(1'b1, 20, tag);
        write_ready = 2'b00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g[3];
        int k;
        rst = 1'b1; i_data = '0; i_valid = 1'b0; i_last = 1'b0; i_flush = 1'b0;
        write_ready = 2'b00; write_size = '0;
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_activate", 64'(write_activate), 64'd0);
        chk("rst_strobe", 64'(write_strobe), 64'd0);
        chk("rst_total", 64'(o_total_count), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_data", 64'(write_data), 64'd0);

        // Ping-pong across three halves with a refilling ready model.
        model_on = 1'b1; write_ready = 2'b11; write_size = SW'(4);
        grants.delete(); halves.delete();
        send(10, 1'b1);
        model_on = 1'b0; write_ready = 2'b00;
        wait_act(1'b0, 20, "A_final_release");
        exp_g = '{2'b01, 2'b10, 2'b01};
        chk("A_grant_count", 64'(grants.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk("A_grant_seq", 64'(grants[i]), 64'(exp_g[i]));
        chk("A_half_count", 64'(halves.size()), 64'd3);
        chk("A_half0", 64'(halves[0]), 64'd4);
        chk("A_half1", 64'(halves[1]), 64'd4);
        chk("A_half2", 64'(halves[2]), 64'd2);
        chk("A_total", 64'(o_total_count), 64'd10);
        refill = '{0, 0};

        // Half 1 only, packet end on the third word.
        grant_one(2'b10, SW'(8), "B_grant");
        chk("B_grant_half", 64'(write_activate), 64'(2'b10));
        send(3, 1'b1);
        chk("B_last_strobe", 64'(write_strobe), 64'd1);
        cyc();
        chk("B_act_edge1", 64'(write_activate), 64'(2'b10));
        cyc();
        chk("B_act_edge2", 64'(write_activate), 64'd0);
        chk("B_strobes", 64'(halves[$]), 64'd3);

        // Idle timeout with a partially filled half.
        grant_one(2'b01, SW'(8), "C_grant");
        send(2, 1'b0);
        k = 0;
        while (o_ready && k < 40) begin cyc(); k++; end
        chk("C_release_delay", 64'(k), 64'(TO));
        cyc();
        chk("C_act_held", 64'(write_activate), 64'(2'b01));
        cyc();
        chk("C_act_dropped", 64'(write_activate), 64'd0);
        chk("C_strobes", 64'(halves[$]), 64'd2);

        // No half available: nothing may move.
        write_ready = 2'b00; i_valid = 1'b1; i_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("D_ready", 64'(o_ready), 64'd0);
            chk("D_strobe", 64'(write_strobe), 64'd0);
            chk("D_activate", 64'(write_activate), 64'd0);
        end
        i_valid = 1'b0;

        // Flush on an empty half is ignored; flush after five words releases.
        grant_one(2'b01, SW'(8), "E_grant");
        i_flush = 1'b1; cyc(); i_flush = 1'b0;
        repeat (3) cyc();
        chk("E_empty_flush_act", 64'(write_activate), 64'(2'b01));
        chk("E_empty_flush_ready", 64'(o_ready), 64'd1);
        send(5, 1'b0);
        i_flush = 1'b1; cyc(); i_flush = 1'b0;
        wait_act(1'b0, 10, "E_flush_release");
        chk("E_strobes", 64'(halves[$]), 64'd5);

        // Reset in the middle of a half.
        grant_one(2'b01, SW'(8), "F_grant");
        send(3, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("F_activate", 64'(write_activate), 64'd0);
        chk("F_strobe", 64'(write_strobe), 64'd0);
        chk("F_total", 64'(o_total_count), 64'd0);
        chk("F_ready", 64'(o_ready), 64'd0);
        cyc();
        chk("F_no_strobe_after", 64'(write_strobe), 64'd0);

        // Randomized traffic with random capacities (including zero).
        chk_caps = 1'b1; model_on = 1'b1; write_ready = 2'b11; refill = '{0, 0};
        for (int i = 0; i < 800; i++) begin
            i_valid    = ($urandom_range(0, 3) != 0);
            i_data     = $urandom();
            i_last     = ($urandom_range(0, 7) == 0);
            write_size = SW'($urandom_range(0, 5));
            cyc();
        end
        send(1, 1'b1);
        model_on = 1'b0; write_ready = 2'b00;
        wait_act(1'b0, 20, "R_final_release");
        chk("R_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
